instruction_fetcher: RTL and testbench

- Upstream stage of the per-block scheduler. Supplies one instruction per scheduler FETCH phase.
- Reports progress on the 3-bit `fetcher_state` bus. The scheduler leaves FETCH only when `fetcher_state` = 3'b010.
- Holds a small direct-mapped instruction cache in front of the shared program-memory port, so loop bodies and reconverged branches skip the memory round-trip.
- Input PC is the warp-leader PC, selected by the core from the scheduler's `current_pc` array.

---
 rtl/instruction_fetcher.sv | 129 ++++++++++++
 tb/tb_instruction_fetcher.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// Instruction fetch stage with a direct-mapped instruction cache in front of
// the shared program-memory port; one instruction per scheduler FETCH phase.
module instruction_fetcher #(
    parameter int PROGRAM_ADDR_BITS = 8,
    parameter int PROGRAM_DATA_BITS = 16,
    parameter int CACHE_LINES       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   core_state,
    input  logic [PROGRAM_ADDR_BITS-1:0] fetch_pc,
    input  logic                         flush,
    output logic [2:0]                   fetcher_state,
    output logic [PROGRAM_DATA_BITS-1:0] instruction,
    output logic                         mem_read_valid,
    output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
    input  logic                         mem_read_ready,
    input  logic [PROGRAM_DATA_BITS-1:0] mem_read_data,
    output logic [15:0]                  hit_count,
    output logic [15:0]                  miss_count
);

    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = PROGRAM_ADDR_BITS - IDX_BITS;
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        FETCHING = 3'b001,
        FETCHED  = 3'b010
    } state_e;

    state_e                         state_q, state_d;
    logic [PROGRAM_DATA_BITS-1:0]   instr_q, instr_d;
    logic                           req_q, req_d;
    logic [PROGRAM_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [15:0]                    hits_q, hits_d;
    logic [15:0]                    misses_q, misses_d;
    logic [CACHE_LINES-1:0]         valid_q, valid_d;

    logic [TAG_BITS-1:0]            tag_mem  [CACHE_LINES];
    logic [PROGRAM_DATA_BITS-1:0]   data_mem [CACHE_LINES];

    logic [IDX_BITS-1:0]            lookup_idx, fill_idx;
    logic [TAG_BITS-1:0]            lookup_tag, fill_tag;
    logic                           lookup_hit, start, fill;

    assign lookup_idx = fetch_pc[IDX_BITS-1:0];
    assign lookup_tag = fetch_pc[PROGRAM_ADDR_BITS-1:IDX_BITS];
    // Fill side uses the registered request address, never the live PC.
    assign fill_idx   = addr_q[IDX_BITS-1:0];
    assign fill_tag   = addr_q[PROGRAM_ADDR_BITS-1:IDX_BITS];
    assign lookup_hit = valid_q[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign start      = (state_q == IDLE) && (core_state == CORE_FETCH);
    assign fill       = (state_q == FETCHING) && mem_read_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_read_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (core_state == CORE_FETCH) state_d = lookup_hit ? FETCHED : FETCHING;
            FETCHING: if (mem_read_ready) state_d = FETCHED;
            FETCHED:  if (core_state == CORE_DECODE) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_d  = instr_q;
        req_d    = req_q;
        addr_d   = addr_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        valid_d  = valid_q;
        if (start && lookup_hit) begin
            instr_d = data_mem[lookup_idx];
            hits_d  = (hits_q == 16'hFFFF) ? hits_q : hits_q + 16'd1;
        end
        if (start && !lookup_hit) begin
            req_d    = 1'b1;
            addr_d   = fetch_pc;
            misses_d = (misses_q == 16'hFFFF) ? misses_q : misses_q + 16'd1;
        end
        if (fill) begin
            instr_d           = mem_read_data;
            req_d             = 1'b0;
            valid_d[fill_idx] = 1'b1;
        end
        // Flush overrides a same-cycle fill; the lookup above already used old valids.
        if (flush) valid_d = '0;
    end

    always_comb begin
        fetcher_state    = state_q;
        instruction      = instr_q;
        mem_read_valid   = req_q;
        mem_read_address = addr_q;
        hit_count        = hits_q;
        miss_count       = misses_q;
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed scenarios plus random
// fetch traffic compared against a line-by-line cache model.
module tb_instruction_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  fetch_pc;
    logic        flush;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int tests = 0;
    int fails = 0;

    // Reference model: each line remembers the full PC it holds.
    bit          m_valid [8];
    logic [7:0]  m_pc    [8];
    logic [15:0] m_data  [8];
    logic [15:0] prog    [256];
    int          n_hits = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    instruction_fetcher #(
        .PROGRAM_ADDR_BITS(8),
        .PROGRAM_DATA_BITS(16),
        .CACHE_LINES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .core_state(core_state),
        .fetch_pc(fetch_pc),
        .flush(flush),
        .fetcher_state(fetcher_state),
        .instruction(instruction),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_clear();
    endtask

    task automatic do_fetch(input logic [7:0] pc, input int lat, input bit flush_start, input bit flush_fill);
        int          idx;
        bit          hit;
        logic [15:0] exp_instr;
        idx       = pc % 8;
        hit       = m_valid[idx] && (m_pc[idx] == pc);
        exp_instr = hit ? m_data[idx] : prog[pc];
        core_state = 3'b001;
        fetch_pc   = pc;
        flush      = flush_start;
        step();
        flush    = 1'b0;
        fetch_pc = 8'($urandom);
        if (flush_start) model_clear();
        if (hit) begin
            n_hits++;
            chk("hit_state", 32'(fetcher_state), 32'h2);
            chk("hit_instr", 32'(instruction), 32'(exp_instr));
            chk("hit_noreq", 32'(mem_read_valid), 32'h0);
            chk("hit_count", 32'(hit_count), 32'(n_hits));
        end else begin
            n_miss++;
            chk("miss_state", 32'(fetcher_state), 32'h1);
            chk("miss_req", 32'(mem_read_valid), 32'h1);
            chk("miss_addr", 32'(mem_read_address), 32'(pc));
            chk("miss_count", 32'(miss_count), 32'(n_miss));
            for (int k = 0; k < lat; k++) begin
                mem_read_data = 16'($urandom);
                step();
                chk("wait_state", 32'(fetcher_state), 32'h1);
                chk("wait_req", 32'(mem_read_valid), 32'h1);
                chk("wait_addr", 32'(mem_read_address), 32'(pc));
            end
            mem_read_ready = 1'b1;
            mem_read_data  = prog[pc];
            flush          = flush_fill;
            step();
            mem_read_ready = 1'b0;
            mem_read_data  = 16'($urandom);
            flush          = 1'b0;
            if (flush_fill) model_clear();
            else begin
                m_valid[idx] = 1'b1;
                m_pc[idx]    = pc;
                m_data[idx]  = prog[pc];
            end
            chk("fill_state", 32'(fetcher_state), 32'h2);
            chk("fill_instr", 32'(instruction), 32'(exp_instr));
            chk("fill_reqdrop", 32'(mem_read_valid), 32'h0);
        end
        core_state = 3'b100;
        step();
        chk("hold_fetched", 32'(fetcher_state), 32'h2);
        core_state = 3'b010;
        step();
        chk("decode_idle", 32'(fetcher_state), 32'h0);
        chk("decode_instr", 32'(instruction), 32'(exp_instr));
        core_state = 3'b000;
    endtask

    initial begin
        reset          = 1'b0;
        core_state     = 3'b000;
        fetch_pc       = 8'h00;
        flush          = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0;
        for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
        prog[8'h05] = 16'hA1B2;
        prog[8'h03] = 16'h1111;
        prog[8'h0B] = 16'h2222;
        model_clear();

        step();
        step();
        chk("rst_state", 32'(fetcher_state), 32'h0);
        chk("rst_instr", 32'(instruction), 32'h0);
        chk("rst_req", 32'(mem_read_valid), 32'h0);
        chk("rst_addr", 32'(mem_read_address), 32'h0);
        chk("rst_hits", 32'(hit_count), 32'h0);
        chk("rst_miss", 32'(miss_count), 32'h0);
        reset = 1'b1;

        core_state = 3'b011;
        step();
        chk("idle_hold", 32'(fetcher_state), 32'h0);
        core_state = 3'b000;

        do_fetch(8'h05, 3, 1'b0, 1'b0);
        do_fetch(8'h05, 3, 1'b0, 1'b0);
        do_fetch(8'h03, 2, 1'b0, 1'b0);
        do_fetch(8'h0B, 1, 1'b0, 1'b0);
        do_fetch(8'h03, 0, 1'b0, 1'b0);
        pulse_flush();
        do_fetch(8'h05, 2, 1'b0, 1'b0);
        do_fetch(8'h05, 2, 1'b1, 1'b0);
        do_fetch(8'h05, 1, 1'b0, 1'b1);
        do_fetch(8'h05, 1, 1'b0, 1'b0);
        do_fetch(8'h05, 1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 14) == 0) pulse_flush();
            do_fetch(8'($urandom_range(0, 23)), int'($urandom_range(0, 4)),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        pulse_flush();
        core_state = 3'b001;
        fetch_pc   = 8'h77;
        step();
        chk("pre_rst_req", 32'(mem_read_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_req", 32'(mem_read_valid), 32'h0);
        chk("async_state", 32'(fetcher_state), 32'h0);
        chk("async_miss", 32'(miss_count), 32'h0);
        chk("async_hits", 32'(hit_count), 32'h0);
        n_hits = 0;
        n_miss = 0;
        model_clear();
        core_state = 3'b000;
        @(negedge clk);
        reset          = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        step();
        mem_read_ready = 1'b0;
        chk("late_ready_state", 32'(fetcher_state), 32'h0);
        chk("late_ready_instr", 32'(instruction), 32'h0);
        chk("late_ready_req", 32'(mem_read_valid), 32'h0);
        do_fetch(8'h05, 1, 1'b0, 1'b0);
        do_fetch(8'h05, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
